// File: rtl/sysbus_mem_responder.sv
// Memory-side responder for Sysbus line reads: accepts a request, acknowledges it,
// waits a fixed latency, then streams one line from an internal backdoor-loaded array.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif

module sysbus_mem_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned BEATS          = 8,
  parameter int unsigned LATENCY        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
  output logic                         bus_reqack,
  output logic                         bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
  input  logic                         bus_respack,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [BUS_DATA_WIDTH-1:0]    ld_data,
  output logic                         busy
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned OP_BIT = BUS_TAG_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [AW-1:0]               base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [LW-1:0]               lat_q, lat_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [BUS_DATA_WIDTH-1:0]   resp_q, resp_d;
  logic                        reqack_q, reqack_d;
  logic                        respcyc_q, respcyc_d;
  logic                        busy_q, busy_d;
  logic [BW-1:0]               beat_nxt;
  logic [BUS_DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

  // Byte address bits below the word offset and above the array index are dropped.
  logic unused_req_bits;
  assign unused_req_bits = ^{bus_req[2:0], bus_req[BUS_DATA_WIDTH-1:3+AW]};

  assign beat_nxt = beat_q + BW'(1);

  // Backdoor load, accepted only while no transfer is in flight.
  always_ff @(posedge clk) begin
    if (ld_en && (state_q == IDLE)) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    tag_d   = tag_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    resp_d  = resp_q;

    case (state_q)
      IDLE: begin
        if (bus_reqcyc) begin
          base_d  = AW'(bus_req >> 3) & ~AW'(BEATS - 1);
          tag_d   = bus_reqtag;
          state_d = ACK;
        end
      end
      ACK: begin
        if (tag_q[OP_BIT] == `SYSBUS_READ) begin
          lat_d   = LW'(LATENCY - 1);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          beat_d  = '0;
          resp_d  = mem_q[base_q];
          state_d = RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      RESP: begin
        if (bus_respack) begin
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d  = '0;
            resp_d  = '0;
            state_d = IDLE;
          end else begin
            // Beat offset ORs into a line-aligned base, so it never leaves the line.
            beat_d = beat_nxt;
            resp_d = mem_q[base_q | AW'(beat_nxt)];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    reqack_d  = (state_d == ACK);
    respcyc_d = (state_d == RESP);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      tag_q     <= '0;
      lat_q     <= '0;
      beat_q    <= '0;
      resp_q    <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      tag_q     <= tag_d;
      lat_q     <= lat_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      busy_q    <= busy_d;
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = tag_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: directed and random line reads
// compared against a word-array model of the memory and the protocol timing rules.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif

module tb_sysbus_mem_responder;

  localparam int unsigned DW    = 64;
  localparam int unsigned TW    = 13;
  localparam int unsigned MW    = 4096;
  localparam int unsigned BEATS = 8;
  localparam int unsigned LAT   = 4;
  localparam int unsigned AW    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          busy;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [DW-1:0] mem_m [MW];

  always #5 clk = ~clk;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_WORDS(MW), .BEATS(BEATS), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int line_base(input logic [63:0] addr);
    return int'(((addr >> 3) % 64'(MW)) / 64'(BEATS) * 64'(BEATS));
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [TW-1:0] read_tag();
    return {`SYSBUS_READ, 12'($urandom)};
  endfunction

  task automatic load(input int a, input logic [63:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    tick();
    ld_en   = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic load_line(input logic [63:0] addr);
    int b;
    b = line_base(addr);
    for (int i = 0; i < int'(BEATS); i++) load(b + i, rnd64());
  endtask

  // mode: 0 = respack always 1, 1 = pattern 1,0,0,..., 2 = random.
  task automatic read_line(input logic [63:0] addr, input logic [TW-1:0] tag, input int mode,
                           input bit ld_at_accept, input bit ld_when_busy, input int abort_beat,
                           input bit prehold, input logic [63:0] next_addr,
                           input logic [TW-1:0] next_tag);
    int b;
    int accepted;
    int cyc;
    bit ack;
    logic [63:0] exp [BEATS];
    b = line_base(addr);
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    if (ld_at_accept) begin
      ld_en   = 1'b1;
      ld_addr = AW'(b + 5);
      ld_data = rnd64();
      mem_m[b + 5] = ld_data;
    end
    tick();
    ld_en = 1'b0;
    check("reqack_pulse", 64'(bus_reqack), 64'd1);
    check("busy_in_ack", 64'(busy), 64'd1);
    bus_reqcyc = 1'b0;
    for (int i = 0; i < int'(BEATS); i++) exp[i] = mem_m[b + i];
    for (int i = 0; i < int'(LAT); i++) begin
      if (i == 0 && ld_when_busy) begin
        ld_en   = 1'b1;
        ld_addr = AW'(b + 2);
        ld_data = ~mem_m[b + 2];
      end
      tick();
      ld_en = 1'b0;
      check("quiet_during_wait", {62'd0, bus_reqack, bus_respcyc}, 64'd0);
    end
    tick();
    accepted = 0;
    cyc = 0;
    while (accepted < int'(BEATS) && cyc < 200) begin
      check("respcyc", 64'(bus_respcyc), 64'd1);
      check("beat_data", bus_resp, exp[accepted]);
      check("resptag", 64'(bus_resptag), 64'(tag));
      if (accepted == abort_beat) begin
        bus_respack = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_respcyc", 64'(bus_respcyc), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_resp", bus_resp, 64'd0);
        tick();
        check("abort_no_more_beats", 64'(bus_respcyc), 64'd0);
        return;
      end
      case (mode)
        0:       ack = 1'b1;
        1:       ack = (cyc % 3 == 0);
        default: ack = 1'($urandom % 2);
      endcase
      bus_respack = ack;
      if (prehold && ack && accepted == int'(BEATS) - 1) begin
        bus_reqcyc = 1'b1;
        bus_req    = next_addr;
        bus_reqtag = next_tag;
      end
      tick();
      if (ack) accepted++;
      cyc++;
    end
    bus_respack = 1'b0;
    check("beats_accepted", 64'(accepted), 64'(BEATS));
    check("end_respcyc", 64'(bus_respcyc), 64'd0);
    check("end_resp_zero", bus_resp, 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("no_same_edge_accept", 64'(bus_reqack), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] a2;
    logic [TW-1:0] t2;
    reset = 1'b1;
    bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // Basic line 0 read at full rate.
    for (int i = 0; i < 8; i++) load(i, 64'h1000 + 64'(i));
    read_line(64'h0, {`SYSBUS_READ, 12'h021}, 0, 0, 0, -1, 0, 0, 0);

    // Unaligned address lands on line 1.
    load_line(64'h40);
    read_line(64'h4C, read_tag(), 0, 0, 0, -1, 0, 0, 0);

    // Throttled acceptance.
    read_line(64'h4C, read_tag(), 1, 0, 0, -1, 0, 0, 0);

    // Write-op tag: acknowledged, never answered, array untouched.
    bus_reqcyc = 1'b1;
    bus_req    = 64'h0;
    bus_reqtag = {~`SYSBUS_READ, 12'h155};
    tick();
    check("wr_reqack", 64'(bus_reqack), 64'd1);
    check("wr_busy_ack", 64'(busy), 64'd1);
    bus_reqcyc = 1'b0;
    tick();
    check("wr_busy_drop", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      check("wr_no_resp", {62'd0, bus_reqack, bus_respcyc}, 64'd0);
      tick();
    end
    read_line(64'h0, read_tag(), 0, 0, 0, -1, 0, 0, 0);

    // Reset during beat 3, then a clean re-read.
    read_line(64'h48, read_tag(), 0, 0, 0, 3, 0, 0, 0);
    read_line(64'h48, read_tag(), 0, 0, 0, -1, 0, 0, 0);

    // Load attempt while busy is ignored.
    read_line(64'h0, read_tag(), 0, 0, 1, -1, 0, 0, 0);
    read_line(64'h0, read_tag(), 2, 0, 0, -1, 0, 0, 0);

    // Address past the array end wraps to line 0.
    read_line(64'(MW) * 64'd8, read_tag(), 0, 0, 0, -1, 0, 0, 0);

    // Load on the same edge as the accept is visible in the line.
    a = rnd64();
    load_line(a);
    read_line(a, read_tag(), 2, 1, 0, -1, 0, 0, 0);

    // Held request restarts the cycle after the final beat.
    a  = rnd64();
    a2 = rnd64();
    t2 = read_tag();
    load_line(a);
    load_line(a2);
    read_line(a, read_tag(), 0, 0, 0, -1, 1, a2, t2);
    read_line(a2, t2, 0, 0, 0, -1, 0, 0, 0);

    // Random addresses and acceptance patterns.
    for (int k = 0; k < 6; k++) begin
      a = rnd64();
      load_line(a);
      read_line(a, read_tag(), 2, 0, 0, -1, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
